// File: rtl/input_pack_mem.sv
// Byte-to-word packer: gathers 16 pixel bytes into one 128-bit frame-memory write.
// Build option: define INPUT_PACK_PARTIAL_FLUSH_EN to write out a partial word on abort.
module input_pack_mem #(
    parameter int unsigned FRAME_WORDS = 19200
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic         input_base_offset,
    input  logic [7:0]   DataIn,
    input  logic         DataValid,
    output logic [15:0]  WriteAddress,
    output logic [127:0] WriteBus,
    output logic         WriteEnable,
    output logic         done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [14:0] LAST_WORD = 15'(FRAME_WORDS - 1);

    state_e         state_q, state_d;
    logic           base_q, base_d;
    logic [14:0]    word_index_q, word_index_d;
    logic [3:0]     byte_count_q, byte_count_d;
    logic [127:0]   lane_q, lane_d;
    logic [15:0]    addr_q, addr_d;
    logic [127:0]   bus_q, bus_d;
    logic           wen_q, wen_d;
    logic           done_q, done_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d      = state_q;
        base_d       = base_q;
        word_index_d = word_index_q;
        byte_count_d = byte_count_q;
        lane_d       = lane_q;
        addr_d       = addr_q;
        bus_d        = bus_q;
        wen_d        = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Bytes presented while idle, including the cycle start rises, are dropped.
                if (start) begin
                    state_d      = ST_FILL;
                    base_d       = input_base_offset;
                    word_index_d = '0;
                    byte_count_d = '0;
                    lane_d       = '0;
                end
            end

            ST_FILL: begin
                if (!start) begin
                    state_d = ST_IDLE;
`ifdef INPUT_PACK_PARTIAL_FLUSH_EN
                    // Unfilled lanes are already zero because lanes clear after every word.
                    if (byte_count_q != 4'd0) begin
                        wen_d  = 1'b1;
                        addr_d = {base_q, word_index_q};
                        bus_d  = lane_q;
                    end
`endif
                    byte_count_d = '0;
                    lane_d       = '0;
                end else if (DataValid) begin
                    lane_d[{byte_count_q, 3'b000} +: 8] = DataIn;
                    byte_count_d = byte_count_q + 4'd1;
                    if (byte_count_q == 4'd15) begin
                        wen_d        = 1'b1;
                        addr_d       = {base_q, word_index_q};
                        bus_d        = {DataIn, lane_q[119:0]};
                        lane_d       = '0;
                        word_index_d = word_index_q + 15'd1;
                        if (word_index_q == LAST_WORD) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                if (start) begin
                    done_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            base_q       <= 1'b0;
            word_index_q <= '0;
            byte_count_q <= '0;
            lane_q       <= '0;
            addr_q       <= '0;
            bus_q        <= '0;
            wen_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            word_index_q <= word_index_d;
            byte_count_q <= byte_count_d;
            lane_q       <= lane_d;
            addr_q       <= addr_d;
            bus_q        <= bus_d;
            wen_q        <= wen_d;
            done_q       <= done_d;
        end
    end

    assign WriteAddress = addr_q;
    assign WriteBus     = bus_q;
    assign WriteEnable  = wen_q;
    assign done         = done_q;

endmodule

// File: tb/tb_input_pack_mem.sv
// Randomised scoreboard bench for input_pack_mem with a byte-queue reference model.
// Honours INPUT_PACK_PARTIAL_FLUSH_EN when predicting abort behaviour.
module tb_input_pack_mem;

    localparam int FW = 2;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         start;
    logic         input_base_offset;
    logic [7:0]   DataIn;
    logic         DataValid;
    logic [15:0]  WriteAddress;
    logic [127:0] WriteBus;
    logic         WriteEnable;
    logic         done;

    input_pack_mem #(.FRAME_WORDS(FW)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .input_base_offset (input_base_offset),
        .DataIn            (DataIn),
        .DataValid         (DataValid),
        .WriteAddress      (WriteAddress),
        .WriteBus          (WriteBus),
        .WriteEnable       (WriteEnable),
        .done              (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0]  addr;
        logic [127:0] data;
        int           cyc;
        bit           last;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;

    // Reference model: frame-level view of what has been accepted so far.
    bit         m_base;
    int         m_idx;
    logic [7:0] m_bytes[$];
    bit         m_active;
    bit         m_done;
    bit         chk_done_next = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [127:0] pack_bytes();
        logic [127:0] w = '0;
        for (int i = 0; i < m_bytes.size(); i++) w[8*i +: 8] = m_bytes[i];
        return w;
    endfunction

    task automatic model_accept(input logic [7:0] b);
        exp_t e;
        if (!m_active) return;
        m_bytes.push_back(b);
        if (m_bytes.size() == 16) begin
            e.addr = {m_base, 15'(m_idx)};
            e.data = pack_bytes();
            e.cyc  = cyc + 1;
            e.last = (m_idx == FW - 1);
            exp_q.push_back(e);
            m_bytes.delete();
            m_idx++;
            if (m_idx == FW) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
    endtask

    task automatic send(input bit v, input logic [7:0] b);
        @(negedge clock);
        DataValid = v;
        DataIn    = v ? b : 8'($urandom);
        if (v) model_accept(b);
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b0, 8'h00);
    endtask

    task automatic start_frame(input bit b);
        @(negedge clock);
        start             = 1'b1;
        input_base_offset = b;
        DataValid         = 1'b1;
        DataIn            = 8'h55;
        m_base   = b;
        m_idx    = 0;
        m_bytes.delete();
        m_active = 1'b1;
        m_done   = 1'b0;
    endtask

    task automatic abort_frame();
        exp_t e;
        @(negedge clock);
        start     = 1'b0;
        DataValid = 1'b0;
`ifdef INPUT_PACK_PARTIAL_FLUSH_EN
        if (m_active && m_bytes.size() != 0) begin
            e.addr = {m_base, 15'(m_idx)};
            e.data = pack_bytes();
            e.cyc  = cyc + 1;
            e.last = 1'b0;
            exp_q.push_back(e);
        end
`endif
        m_active = 1'b0;
        m_bytes.delete();
        idle(1);
        check("done_fall", 128'(done), 128'(0));
    endtask

    task automatic drain(input string name);
        idle(3);
        check(name, 128'(exp_q.size()), 128'(0));
        exp_q.delete();
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes a write.
    always @(negedge clock) begin
        exp_t e;
        if (chk_done_next) begin
            chk_done_next = 1'b0;
            check("done_rise", 128'(done), 128'(1));
        end
        if (reset_n && WriteEnable) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_en", 128'(WriteEnable), 128'(0));
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 128'(WriteAddress), 128'(e.addr));
                check("write_data", WriteBus, e.data);
                check("write_cycle", 128'(cyc), 128'(e.cyc));
                if (e.last) begin
                    check("done_before_last", 128'(done), 128'(0));
                    chk_done_next = 1'b1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n           = 1'b0;
        start             = 1'b0;
        input_base_offset = 1'b0;
        DataIn            = 8'h00;
        DataValid         = 1'b0;
        m_active          = 1'b0;
        m_done            = 1'b0;
        m_base            = 1'b0;
        m_idx             = 0;
        repeat (3) @(negedge clock);
        check("rst_we",   128'(WriteEnable), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_addr", 128'(WriteAddress), 128'(0));
        check("rst_bus",  WriteBus, 128'(0));
        @(negedge clock);
        reset_n = 1'b1;
        idle(2);

        // Full frame at base 0, ascending bytes; trailing bytes after completion ignored.
        start_frame(1'b0);
        for (int i = 0; i < 32; i++) send(1'b1, 8'(i));
        for (int i = 0; i < 4; i++) send(1'b1, 8'hEE);
        idle(3);
        check("done_level", 128'(done), 128'(m_done));
        abort_frame();
        drain("drain_frame0");

        // Base 1 with the offset input toggled mid-frame.
        start_frame(1'b1);
        for (int i = 0; i < 32; i++) begin
            send(1'b1, 8'(i));
            if (i == 8 || i == 20) input_base_offset = ~input_base_offset;
        end
        idle(3);
        check("done_level", 128'(done), 128'(m_done));
        abort_frame();
        drain("drain_frame1");

        // Gapped stream: one valid byte every third cycle.
        start_frame(1'b0);
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 8'hA0 + 8'(i));
            send(1'b0, 8'h00);
            send(1'b0, 8'h00);
        end
        idle(2);
        check("done_partial_frame", 128'(done), 128'(0));
        abort_frame();
        drain("drain_gapped");

        // Abort after five bytes.
        start_frame(1'b0);
        for (int i = 0; i < 5; i++) send(1'b1, 8'h11 + 8'(i));
        abort_frame();
        drain("drain_abort5");

        // Reset in the middle of a word, then restart cleanly.
        start_frame(1'b1);
        for (int i = 0; i < 7; i++) send(1'b1, 8'h70 + 8'(i));
        @(negedge clock);
        reset_n   = 1'b0;
        start     = 1'b0;
        DataValid = 1'b0;
        m_active  = 1'b0;
        m_bytes.delete();
        exp_q.delete();
        @(negedge clock);
        check("midrst_we",   128'(WriteEnable), 128'(0));
        check("midrst_addr", 128'(WriteAddress), 128'(0));
        check("midrst_bus",  WriteBus, 128'(0));
        @(negedge clock);
        reset_n = 1'b1;
        start_frame(1'b1);
        for (int i = 0; i < 32; i++) send(1'b1, 8'($urandom));
        idle(3);
        check("done_level", 128'(done), 128'(m_done));
        abort_frame();
        drain("drain_after_reset");

        // Randomised frames: random base, length, gaps and abort point.
        for (int r = 0; r < 15; r++) begin
            start_frame(1'($urandom));
            for (int i = 0, n = $urandom_range(0, 40); i < n; i++) begin
                if ($urandom_range(0, 3) == 0) send(1'b0, 8'h00);
                send(1'b1, 8'($urandom));
            end
            idle(3);
            check("done_level_rand", 128'(done), 128'(m_done));
            abort_frame();
            drain("drain_rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/input_pack_mem.md
# input_pack_mem

Byte-to-word packer on the input side of the frame pipeline: accepts a stream of 8-bit pixels with a valid strobe, packs 16 consecutive bytes into one 128-bit word and writes it to frame memory at consecutive word addresses within a selectable half (bit 15 = buffer select). It is the write-side counterpart of the output fetch stage, which reads the same 128-bit words and unpacks them to bytes. It asserts `done` once a full frame of words has been written.

## Interface
- `FRAME_WORDS`, 19200: 128-bit words per frame; legal range 1..32767.
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame enable level; high = run, low = abort/idle.
- `input_base_offset`  in  1  buffer-half select; sampled on the IDLE→FILL transition.
- `DataIn`  in  8  pixel byte.
- `DataValid`  in  1  `DataIn` valid this cycle.
- `WriteAddress`  out  16  {base, word_index[14:0]}.
- `WriteBus`  out  128  packed word.
- `WriteEnable`  out  1  one-cycle write strobe; memory accepts every cycle, no backpressure.
- `done`  out  1  frame complete, level.

## Operation
- Reset: all outputs 0, state IDLE, byte_count 0, word_index 0, lane register 0, base 0.
- States: IDLE, FILL, DONE.
- IDLE: `start`=1 → FILL; latch base ← `input_base_offset`, word_index ← 0, byte_count ← 0. `DataValid` in IDLE ignored, including the cycle `start` rises.
- FILL, `DataValid`=1: byte stored in lane byte_count, bits [8k+7:8k] for k=byte_count (first byte of a word → [7:0], 16th → [127:120]); byte_count increments, 4-bit, wraps 15→0.
- FILL, 16th byte (byte_count=15 and valid): next edge drives `WriteBus` = full word (including that byte), `WriteAddress` = {base, word_index}, `WriteEnable`=1; word_index increments.
- Final word (word_index = FRAME_WORDS-1 written) → DONE; further `DataValid` ignored.
- DONE: `done`=1 while `start`=1; `start`=0 → IDLE, `done` ← 0.
- FILL, `start`=0: → IDLE next edge; partial word handled per Configuration; word_index reset on next start.
- `input_base_offset` changes mid-frame have no effect; new value taken at next IDLE→FILL.
- `WriteAddress`/`WriteBus` hold last values when `WriteEnable`=0.

## Timing
- IDLE→FILL: 1 cycle after `start` sampled high; first acceptable byte is the following cycle.
- Byte accept to lane: 1 edge. 16th byte accepted at edge N → `WriteEnable` high in cycle N+1 (registered), low in N+2 unless another word completes.
- Sustained throughput: one byte per cycle → one write per 16 cycles.
- `done` rises at the edge after the final write's `WriteEnable` cycle begins (i.e. concurrent with `WriteEnable` falling); falls one edge after `start` sampled low.
- Async reset mid-frame: all state and outputs to reset values immediately; any in-flight write is lost.

## Configuration
- `INPUT_PACK_PARTIAL_FLUSH_EN` defined: on `start` falling in FILL with byte_count ≠ 0, one write is issued next cycle with received lanes filled and unfilled lanes zero, at {base, word_index}; then IDLE. byte_count = 0 → no write.
- Undefined: partial word discarded, no write, straight to IDLE.
- Neither variant asserts `done` on abort.

## Test plan
- FRAME_WORDS=2, base=0, bytes 0x00..0x1F on consecutive cycles → writes addr 0x0000 data 0x0F0E..0100, addr 0x0001 data 0x1F1E..1110; `done`=1 after second write.
- base=1, same stream → addresses 0x8000, 0x8001; toggling `input_base_offset` mid-frame leaves addresses unchanged.
- Gapped valid (valid every 3rd cycle), 16 bytes 0xA0..0xAF → single write 0xAFAE..A1A0 one cycle after 16th accepted byte.
- `DataValid`=1 with 0x55 in cycle `start` rises → byte not captured; first word's lane 0 is the next valid byte.
- Abort after 5 bytes 0x11..0x15: macro off → no write; macro on → write 0x0000..0015141312 11 (lanes 5–15 zero) at current address; `done` stays 0.
- Assert `reset_n` low mid-word then restart → no stale write, first word starts at lane 0, address {base,0}.
